// File: rtl/alu_transfer_unit_pkg.sv
// Package alu_pkg: shared constants for the ALU transfer path.
//   DEFAULT_WIDTH    default operand/result width
//   MODE_PASS..ZERO  3-bit transform selects carried on in_mode
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_NOT  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_SWAP = 3'b110;
  localparam logic [2:0] MODE_ZERO = 3'b111;

endpackage

// File: rtl/alu_transfer_unit_if.sv
// Handshake bundle between the operand side, the transfer unit and the
// ALU result bus.
//   in_valid/in_ready/in_data/in_mode       operand channel (producer -> unit)
//   out_valid/out_ready/out_data/out_zero/out_neg  result channel (unit -> consumer)
// Modports: slave = the transfer unit, master = the surrounding producer/consumer.
interface alu_transfer_unit_if #(
  parameter int unsigned WIDTH = alu_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg
  );
endinterface

// File: rtl/alu_transfer_unit_op.sv
// transfer_op: combinational unary transform applied to an operand.
//   in_data   operand
//   in_mode   transform select (alu_pkg MODE_*)
//   out_data  transformed word
module transfer_op
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned HALF = WIDTH / 2;

  always_comb begin
    out_data = '0;
    case (in_mode)
      MODE_PASS: out_data = in_data;
      MODE_NOT:  out_data = ~in_data;
      MODE_SHL:  out_data = {in_data[WIDTH-2:0], 1'b0};
      MODE_SHR:  out_data = {1'b0, in_data[WIDTH-1:1]};
      MODE_ROR:  out_data = {in_data[0], in_data[WIDTH-1:1]};
      MODE_ROL:  out_data = {in_data[WIDTH-2:0], in_data[WIDTH-1]};
      MODE_SWAP: out_data = {in_data[HALF-1:0], in_data[WIDTH-1:HALF]};
      MODE_ZERO: out_data = '0;
      default:   out_data = '0;
    endcase
  end

endmodule

// File: rtl/alu_transfer_unit.sv
// alu_transfer_unit: accepts operands over a valid/ready handshake, applies
// the selected unary transform on entry and buffers results in a DEPTH-entry
// FIFO presented with zero/negative flags.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous clear of FIFO pointers/count
//   bus    operand and result channels (alu_transfer_unit_if.slave)
//   count  entries currently held (0..DEPTH)
module alu_transfer_unit
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  alu_transfer_unit_if.slave   bus,
  output logic [AW:0]          count
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] xform_data;
  logic             push;
  logic             pop;

  transfer_op #(.WIDTH(WIDTH)) u_op (
    .in_data  (bus.in_data),
    .in_mode  (bus.in_mode),
    .out_data (xform_data)
  );

  // Handshake outputs depend only on registered state.
  assign bus.in_ready  = (count != CNT_FULL);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_zero  = (bus.out_data == '0);
  assign bus.out_neg   = bus.out_data[WIDTH-1];

  // A flush discards any handshake completing in the same cycle.
  assign push = bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= xform_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_transfer_unit.sv
module tb_alu_transfer_unit;
  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  int q[$];

  alu_transfer_unit_if #(.WIDTH(W)) bus ();

  alu_transfer_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference transform expressed arithmetically on an 8-bit value.
  function automatic int ref_xform(int x, int m);
    case (m)
      0: return x;
      1: return 255 - x;
      2: return (x * 2) % 256;
      3: return x / 2;
      4: return x / 2 + (x % 2) * 128;
      5: return (x * 2) % 256 + x / 128;
      6: return (x % 16) * 16 + x / 16;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"},    32'(count),         32'(q.size()));
    check({tag, ".in_ready"}, 32'(bus.in_ready),  32'(q.size() != D));
    check({tag, ".out_valid"},32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, ".out_data"}, 32'(bus.out_data), 32'(q[0]));
      check({tag, ".out_zero"}, 32'(bus.out_zero), 32'(q[0] == 0));
      check({tag, ".out_neg"},  32'(bus.out_neg),  32'(q[0] >= 128));
    end
  endtask

  // One clock: predict from the inputs currently applied, advance, then compare.
  task automatic cycle(input string tag);
    bit do_push, do_pop;
    int word;
    do_push = (bus.in_valid === 1'b1) && (q.size() < D) && !flush;
    do_pop  = (bus.out_ready === 1'b1) && (q.size() > 0) && !flush;
    word    = ref_xform(int'(bus.in_data), int'(bus.in_mode));
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(word);
    end
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] m, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.out_ready = r;
  endtask

  logic [7:0] spec_exp [8];

  initial begin
    spec_exp = '{8'b10000101, 8'b01111010, 8'b00001010, 8'b01000010,
                 8'b11000010, 8'b00001011, 8'b01011000, 8'b00000000};

    // Reset with a pending push on the input.
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b1, 8'h5a, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.count",     32'(count),         32'd0);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.in_ready",  32'(bus.in_ready),  32'd1);
    check("reset.out_zero",  32'(bus.out_zero),  32'd1);
    check("reset.out_data",  32'(bus.out_data),  32'd0);
    check("reset.out_neg",   32'(bus.out_neg),   32'd0);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;

    // Each mode on 8'b10000101, one-cycle latency.
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 8'b10000101, 3'(m), 1'b1);
      cycle("mode.push");
      check("mode.spec_value", 32'(bus.out_data), 32'(spec_exp[m]));
      drive(1'b0, 8'h00, 3'd0, 1'b1);
      cycle("mode.pop");
    end

    // Fill past capacity with the consumer stalled, then drain.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(0, 6)), 1'b0);
      cycle("fill");
      if (i == 3) check("fill.full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("fill.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 3'd0, 1'b1);
      cycle("drain");
    end
    check("drain.empty", 32'(bus.out_valid), 32'd0);
    cycle("drain.idle_pop");

    // Steady push+pop at count=2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      cycle("conc.prefill");
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      cycle("conc.stream");
      check("conc.count2", 32'(count), 32'd2);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    repeat (2) cycle("conc.drain");

    // Flush at count=3 discards the same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 3'd0, 1'b0);
      cycle("flush.prefill");
    end
    drive(1'b1, 8'h77, 3'd0, 1'b1);
    flush = 1'b1;
    cycle("flush.edge");
    flush = 1'b0;
    check("flush.count",     32'(count),         32'd0);
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'h3c, 3'd0, 1'b0);
    cycle("flush.next_push");
    check("flush.fresh_word", 32'(bus.out_data), 32'h3c);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    cycle("flush.drain");

    // Asynchronous reset between edges at count=2.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      cycle("areset.prefill");
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("areset.out_valid", 32'(bus.out_valid), 32'd0);
    check("areset.count",     32'(count),         32'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h81, 3'd5, 1'b0);
    cycle("areset.push");
    check("areset.reappear", 32'(bus.out_data), 32'h03);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    cycle("areset.drain");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 15) == 0);
      cycle("random");
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
